// File: rtl/rvvi_depacketizer_pkg.sv
// Shared RVVI framing constants, core-config stub and record-width helpers
// imported by the packetizer, trigger generator and depacketizer.
package rvvi_depacketizer_pkg;

  typedef struct packed {
    int unsigned XLEN;
  } cvw_t;

  localparam cvw_t        DEFAULT_CVW      = '{XLEN: 32'd64};
  localparam logic [47:0] DEFAULT_DST_MAC  = 48'h8F54_0000_1654;
  localparam logic [47:0] DEFAULT_SRC_MAC  = 48'h4502_1111_6843;
  localparam logic [15:0] DEFAULT_ETH_TYPE = 16'h005C;
  localparam int unsigned HDR_WORDS        = 32'd4;
  localparam int unsigned HDR_BITS         = 32'd112;

  typedef enum logic [1:0] {
    HDR     = 2'd0,
    PAYLOAD = 2'd1,
    HOLD    = 2'd2,
    DROP    = 2'd3
  } depktState_t;

  function automatic int unsigned rvviWidth(input cvw_t cfg, input int unsigned maxCsrs);
    return 32'd72 + 32'd5 * cfg.XLEN + maxCsrs * (cfg.XLEN + 32'd16);
  endfunction

  // Beats per frame: Ethernet header plus record, rounded up to whole words
  function automatic int unsigned rvviWords(input int unsigned recWidth);
    return (HDR_BITS + recWidth + 32'd31) / 32'd32;
  endfunction

  function automatic logic [15:0] satInc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/rvvi_depacketizer_if.sv
// 32-bit AXI-Stream receive channel carrying RVVI Ethernet payload beats.
interface rvvi_depacketizer_if;

  logic [31:0] RvviAxiRdata;
  logic [3:0]  RvviAxiRstrb;
  logic        RvviAxiRlast;
  logic        RvviAxiRvalid;
  logic        RvviAxiRready;

  modport master (
    output RvviAxiRdata, RvviAxiRstrb, RvviAxiRlast, RvviAxiRvalid,
    input  RvviAxiRready
  );

  modport slave (
    input  RvviAxiRdata, RvviAxiRstrb, RvviAxiRlast, RvviAxiRvalid,
    output RvviAxiRready
  );

endinterface

// File: rtl/rvvi_hdrcheck.sv
// Combinational header-word comparator: matches one of the four header words
// against the expected destination MAC, source MAC and EtherType.
module rvvi_hdrcheck
  import rvvi_depacketizer_pkg::*;
#(
  parameter logic [47:0] EXP_DST_MAC  = DEFAULT_DST_MAC,
  parameter logic [47:0] EXP_SRC_MAC  = DEFAULT_SRC_MAC,
  parameter logic [15:0] EXP_ETH_TYPE = DEFAULT_ETH_TYPE
) (
  input  logic [1:0]  wordIdx,
  input  logic [31:0] wordData,
  output logic        hdrMatch
);

  // Word 3 only carries EtherType in its low half; the upper half is record data
  always_comb begin
    hdrMatch = 1'b0;
    case (wordIdx)
      2'd0:    hdrMatch = (wordData == EXP_DST_MAC[31:0]);
      2'd1:    hdrMatch = (wordData == {EXP_SRC_MAC[15:0], EXP_DST_MAC[47:32]});
      2'd2:    hdrMatch = (wordData == EXP_SRC_MAC[47:16]);
      2'd3:    hdrMatch = (wordData[15:0] == EXP_ETH_TYPE);
      default: hdrMatch = 1'b0;
    endcase
  end

endmodule

// File: rtl/rvvi_depacketizer.sv
// Receive-side RVVI depacketizer: validates the Ethernet header of each
// AXI-Stream frame and reassembles one RVVI record per frame for a consumer.
module rvvi_depacketizer
  import rvvi_depacketizer_pkg::*;
#(
  parameter cvw_t        P            = DEFAULT_CVW,
  parameter int unsigned MAX_CSRS     = 32'd5,
  parameter int unsigned RVVI_WIDTH   = rvviWidth(P, MAX_CSRS),
  parameter logic [47:0] EXP_DST_MAC  = DEFAULT_DST_MAC,
  parameter logic [47:0] EXP_SRC_MAC  = DEFAULT_SRC_MAC,
  parameter logic [15:0] EXP_ETH_TYPE = DEFAULT_ETH_TYPE
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  rvvi_depacketizer_if.slave    rvviAxi,
  output logic [RVVI_WIDTH-1:0] RvviOut,
  output logic                  RvviOutValid,
  input  logic                  RvviOutReady,
  output logic [15:0]           FrameGoodCnt,
  output logic [15:0]           FrameDropCnt,
  output logic                  ShortFrame
);

  localparam int unsigned NWORDS = rvviWords(RVVI_WIDTH);
  localparam int unsigned CNT_W  = $clog2(NWORDS + 32'd1);
  localparam int unsigned IDX_W  = $clog2(RVVI_WIDTH + 32'd32);

  depktState_t           state_r, state_s;
  logic [CNT_W-1:0]      wordCnt_r, wordCnt_s;
  logic [RVVI_WIDTH-1:0] record_r, record_s;
  logic [RVVI_WIDTH+31:0] recWide_s;
  logic [IDX_W-1:0]      baseBit_s;
  logic [31:0]           beatData_s;
  logic                  beatFire_s, hdrMatch_s, lastWord_s;
  logic                  axiReady_r, outValid_r, shortFrame_r, shortFrame_s;
  logic                  goodInc_s, dropInc_s;
  logic [15:0]           goodCnt_r, dropCnt_r;

  rvvi_hdrcheck #(
    .EXP_DST_MAC  (EXP_DST_MAC),
    .EXP_SRC_MAC  (EXP_SRC_MAC),
    .EXP_ETH_TYPE (EXP_ETH_TYPE)
  ) u_hdrcheck (
    .wordIdx  (wordCnt_r[1:0]),
    .wordData (rvviAxi.RvviAxiRdata),
    .hdrMatch (hdrMatch_s)
  );

  assign beatFire_s = rvviAxi.RvviAxiRvalid & axiReady_r;
  assign lastWord_s = (wordCnt_r == CNT_W'(NWORDS - 32'd1));
  assign beatData_s = rvviAxi.RvviAxiRdata & {{8{rvviAxi.RvviAxiRstrb[3]}}, {8{rvviAxi.RvviAxiRstrb[2]}},
                                              {8{rvviAxi.RvviAxiRstrb[1]}}, {8{rvviAxi.RvviAxiRstrb[0]}}};
  // Payload beat k lands at record bit 16+32*(k-4); the 32 spare bits absorb the clipped tail
  assign baseBit_s  = IDX_W'(32'd16 + 32'd32 * (32'(wordCnt_r) - HDR_WORDS));

  // Next-state, record update and counter-strobe decode
  always_comb begin
    state_s      = state_r;
    wordCnt_s    = wordCnt_r;
    record_s     = record_r;
    shortFrame_s = shortFrame_r;
    goodInc_s    = 1'b0;
    dropInc_s    = 1'b0;
    recWide_s    = {32'b0, record_r};
    recWide_s[baseBit_s +: 32] = beatData_s;
    case (state_r)
      HDR: begin
        if (beatFire_s) begin
          if (!hdrMatch_s || rvviAxi.RvviAxiRlast) begin
            dropInc_s = 1'b1;
            wordCnt_s = '0;
            state_s   = rvviAxi.RvviAxiRlast ? HDR : DROP;
          end else if (wordCnt_r == CNT_W'(HDR_WORDS - 32'd1)) begin
            record_s       = '0;
            record_s[15:0] = beatData_s[31:16];
            wordCnt_s      = wordCnt_r + CNT_W'(1);
            state_s        = PAYLOAD;
          end else begin
            wordCnt_s = wordCnt_r + CNT_W'(1);
          end
        end else begin
          state_s = HDR;
        end
      end
      PAYLOAD: begin
        if (beatFire_s) begin
          record_s = recWide_s[RVVI_WIDTH-1:0];
          if (rvviAxi.RvviAxiRlast) begin
            shortFrame_s = !lastWord_s;
            wordCnt_s    = '0;
            state_s      = HOLD;
          end else if (lastWord_s) begin
            dropInc_s = 1'b1;
            wordCnt_s = '0;
            state_s   = DROP;
          end else begin
            wordCnt_s = wordCnt_r + CNT_W'(1);
          end
        end else begin
          state_s = PAYLOAD;
        end
      end
      HOLD: begin
        if (RvviOutReady) begin
          goodInc_s = 1'b1;
          state_s   = HDR;
        end else begin
          state_s = HOLD;
        end
      end
      DROP: begin
        if (beatFire_s && rvviAxi.RvviAxiRlast) begin
          state_s = HDR;
        end else begin
          state_s = DROP;
        end
      end
      default: begin
        state_s   = HDR;
        wordCnt_s = '0;
      end
    endcase
  end

  // State, record, handshake and statistics registers
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_r      <= HDR;
      wordCnt_r    <= '0;
      record_r     <= '0;
      shortFrame_r <= 1'b0;
      axiReady_r   <= 1'b0;
      outValid_r   <= 1'b0;
      goodCnt_r    <= 16'd0;
      dropCnt_r    <= 16'd0;
    end else begin
      state_r      <= state_s;
      wordCnt_r    <= wordCnt_s;
      record_r     <= record_s;
      shortFrame_r <= shortFrame_s;
      axiReady_r   <= (state_s != HOLD);
      outValid_r   <= (state_s == HOLD);
      goodCnt_r    <= goodInc_s ? satInc16(goodCnt_r) : goodCnt_r;
      dropCnt_r    <= dropInc_s ? satInc16(dropCnt_r) : dropCnt_r;
    end
  end

  assign rvviAxi.RvviAxiRready = axiReady_r;
  assign RvviOut               = record_r;
  assign RvviOutValid          = outValid_r;
  assign FrameGoodCnt          = goodCnt_r;
  assign FrameDropCnt          = dropCnt_r;
  assign ShortFrame            = shortFrame_r;

endmodule

// File: tb/tb_rvvi_depacketizer.sv
// Scoreboard bench for rvvi_depacketizer with XLEN=64, MAX_CSRS=3 (632-bit record, 24 beats).
module tb_rvvi_depacketizer;
  import rvvi_depacketizer_pkg::*;

  localparam cvw_t        TB_CVW  = '{XLEN: 32'd64};
  localparam int unsigned TB_CSRS = 32'd3;
  localparam int          W       = 632;
  localparam int          NW      = 24;

  typedef struct packed {
    logic [W-1:0] rec;
    logic         isShort;
  } expRec_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [W-1:0]   rvviOut;
  logic           outValid, outReady, shortFrame;
  logic [15:0]    goodCnt, dropCnt;

  expRec_t        expQ[$];
  expRec_t        monE;
  int             checks = 0;
  int             errors = 0;
  int             expGood = 0;
  int             expDrop = 0;

  always #5 clk = ~clk;

  rvvi_depacketizer_if rxIf();

  rvvi_depacketizer #(
    .P        (TB_CVW),
    .MAX_CSRS (TB_CSRS)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .rvviAxi       (rxIf.slave),
    .RvviOut       (rvviOut),
    .RvviOutValid  (outValid),
    .RvviOutReady  (outReady),
    .FrameGoodCnt  (goodCnt),
    .FrameDropCnt  (dropCnt),
    .ShortFrame    (shortFrame)
  );

  // Monitor: every delivered record is popped from the scoreboard and compared
  always @(negedge clk) begin
    if (rst_n && outValid && outReady) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL record: unexpected record %0h, required none", rvviOut);
      end else begin
        monE = expQ.pop_front();
        if (rvviOut !== monE.rec || shortFrame !== monE.isShort) begin
          errors++;
          $display("FAIL record: got %0h short=%b, required %0h short=%b",
                   rvviOut, shortFrame, monE.rec, monE.isShort);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mkRec(input logic [7:0] seed);
    logic [W-1:0] r;
    for (int i = 0; i < W / 8; i++) r[8*i +: 8] = seed + 8'(i);
    return r;
  endfunction

  function automatic logic [32*NW-1:0] mkFrame(input logic [W-1:0] rec);
    logic [32*NW-1:0] f;
    f = '0;
    f[112+W-1:0] = {rec, 16'h005C, 48'h4502_1111_6843, 48'h8F54_0000_1654};
    return f;
  endfunction

  task automatic sendBeat(input logic [31:0] d, input logic [3:0] s, input logic l, inout int cyc);
    int   g;
    logic acc;
    g = 0;
    acc = 1'b0;
    rxIf.RvviAxiRdata  = d;
    rxIf.RvviAxiRstrb  = s;
    rxIf.RvviAxiRlast  = l;
    rxIf.RvviAxiRvalid = 1'b1;
    while (!acc && g < 1000) begin
      @(negedge clk);
      acc = rxIf.RvviAxiRready;
      @(posedge clk);
      #1;
      g++;
      cyc++;
    end
    rxIf.RvviAxiRvalid = 1'b0;
    rxIf.RvviAxiRlast  = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL beatTimeout: ready=%b after %0d cycles, required 1", acc, g);
    end
  endtask

  // Sends beats [first, upto); Rlast on beat lastBeat; strbVal applied on beat strbBeat
  task automatic sendFrame(input logic [32*NW-1:0] f, input int first, input int upto,
                           input int lastBeat, input int strbBeat, input logic [3:0] strbVal,
                           output int cyc);
    cyc = 0;
    for (int k = first; k < upto; k++) begin
      logic [31:0] w;
      w = (k < NW) ? f[32*k +: 32] : 32'hDEAD_BEEF;
      sendBeat(w, (k == strbBeat) ? strbVal : 4'hF, (k == lastBeat), cyc);
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (expQ.size() != 0 && g < 2000) begin
      @(posedge clk);
      g++;
    end
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d records outstanding, required 0", expQ.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chkCounters(input string tag);
    chk({tag, "_good"}, W'(goodCnt), W'(expGood));
    chk({tag, "_drop"}, W'(dropCnt), W'(expDrop));
  endtask

  initial begin
    int               cyc;
    int               g;
    logic [W-1:0]     r, m, rA, rB, snap;
    logic [32*NW-1:0] f, fA, fB;
    logic             stable, rdyLow;

    rst_n              = 1'b0;
    outReady           = 1'b1;
    rxIf.RvviAxiRdata  = 32'd0;
    rxIf.RvviAxiRstrb  = 4'd0;
    rxIf.RvviAxiRlast  = 1'b0;
    rxIf.RvviAxiRvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", rvviOut, '0);
    chk("rst_valid", W'(outValid), W'(0));
    chk("rst_ready", W'(rxIf.RvviAxiRready), W'(0));
    chk("rst_short", W'(shortFrame), W'(0));
    chkCounters("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Good full-length frame; valid must already be high right after the Rlast edge
    r = mkRec(8'hA5);
    expQ.push_back('{rec: r, isShort: 1'b0});
    sendFrame(mkFrame(r), 0, NW, NW - 1, -1, 4'hF, cyc);
    chk("latency", W'(outValid), W'(1));
    drain();
    expGood = 1;
    chkCounters("good1");

    // Wrong EtherType: dropped, every beat accepted on its first cycle
    f = mkFrame(mkRec(8'h5A));
    f[111:96] = 16'h0800;
    sendFrame(f, 0, NW, NW - 1, -1, 4'hF, cyc);
    chk("dropCycles", W'(cyc), W'(NW));
    drain();
    expDrop = 1;
    chkCounters("badEth");

    // Short frame ending at beat 10 with a partial strobe on beat 5
    r = mkRec(8'h3C);
    m = r;
    m[64 +: 16] = 16'h0000;
    for (int i = 240; i < W; i++) m[i] = 1'b0;
    expQ.push_back('{rec: m, isShort: 1'b1});
    sendFrame(mkFrame(r), 0, 11, 10, 5, 4'b0011, cyc);
    drain();
    expGood = 2;
    chkCounters("short");

    // Oversize 25-beat frame, then a normal frame
    sendFrame(mkFrame(mkRec(8'h77)), 0, NW + 1, NW, -1, 4'hF, cyc);
    chk("oversizeCycles", W'(cyc), W'(NW + 1));
    drain();
    expDrop = 2;
    chkCounters("oversize");
    r = mkRec(8'hC3);
    expQ.push_back('{rec: r, isShort: 1'b0});
    sendFrame(mkFrame(r), 0, NW, NW - 1, -1, 4'hF, cyc);
    drain();
    expGood = 3;
    chkCounters("afterOversize");

    // Consumer back-pressure for 50 cycles with a second frame waiting
    outReady = 1'b0;
    rA = mkRec(8'h19);
    rB = mkRec(8'h81);
    fA = mkFrame(rA);
    fB = mkFrame(rB);
    expQ.push_back('{rec: rA, isShort: 1'b0});
    expQ.push_back('{rec: rB, isShort: 1'b0});
    fork
      begin
        sendFrame(fA, 0, NW, NW - 1, -1, 4'hF, cyc);
        sendFrame(fB, 0, NW, NW - 1, -1, 4'hF, cyc);
      end
      begin
        g = 0;
        while (!outValid && g < 1000) begin
          @(negedge clk);
          g++;
        end
        snap   = rvviOut;
        stable = 1'b1;
        rdyLow = 1'b1;
        repeat (50) begin
          @(negedge clk);
          if (rvviOut !== snap) stable = 1'b0;
          if (rxIf.RvviAxiRready !== 1'b0) rdyLow = 1'b0;
        end
        chk("holdValid", W'(outValid), W'(1));
        chk("holdStable", W'(stable), W'(1));
        chk("holdReadyLow", W'(rdyLow), W'(1));
        chk("holdRecord", snap, rA);
        @(posedge clk);
        #1;
        outReady = 1'b1;
      end
    join
    drain();
    expGood = 5;
    chkCounters("hold");

    // Reset in the middle of a frame; the tail is then dropped from HDR
    f = mkFrame(mkRec(8'h11));
    sendFrame(f, 0, 12, -1, -1, 4'hF, cyc);
    rst_n = 1'b0;
    #1;
    chk("midRst_out", rvviOut, '0);
    chk("midRst_ready", W'(rxIf.RvviAxiRready), W'(0));
    expGood = 0;
    expDrop = 0;
    chkCounters("midRst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sendFrame(f, 12, NW, NW - 1, -1, 4'hF, cyc);
    drain();
    expDrop = 1;
    chkCounters("tailDrop");
    r = mkRec(8'hE7);
    expQ.push_back('{rec: r, isShort: 1'b0});
    sendFrame(mkFrame(r), 0, NW, NW - 1, -1, 4'hF, cyc);
    drain();
    expGood = 1;
    chkCounters("afterRst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of stimulus");
    $fatal(1, "watchdog expired");
  end

endmodule
